mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage sequencer for the single data-bus port.
- Takes one load/store per instruction from the MEM stage and runs the dbus request/response handshake.
- Stalls the pipeline while the access is outstanding.
- Returns the aligned, sign/zero-extended load word that the writeback data mux selects for load ops.

Parameters:
ALIGN_CHECK, 1, 1 = misaligned accesses are rejected without a bus request; 0 = issued as-is.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  MEM stage holds a load or store
req_is_store  in  1  1 = store, 0 = load
req_addr  in  64  byte address
req_size  in  3  0=byte, 1=half, 2=word, 3=double; 4-7 illegal
req_unsigned  in  1  load zero-extends when 1
req_wdata  in  64  store data, LSB-aligned
stall  out  1  pipeline must hold MEM and earlier stages
done  out  1  one-cycle pulse: access finished, results valid this cycle
mem_rdata  out  64  extended load data, valid when done and load
misalign  out  1  valid with done: access rejected as misaligned
dreq_valid  out  1  bus request valid
dreq_addr  out  64  bus address (req_addr, unmodified)
dreq_size  out  3  copy of req_size
dreq_strobe  out  8  byte-lane write enables; 0 for loads
dreq_data  out  64  store data shifted to byte lane
dresp_addr_ok  in  1  bus accepted the address phase
dresp_data_ok  in  1  bus data phase complete
dresp_data  in  64  raw 64-bit aligned read data

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset (any time, async) -> IDLE.
- Reset values: all outputs 0, request registers 0.
- IDLE:
  - req_valid=1: latch addr/size/unsigned/is_store/wdata into registers.
  - If misaligned and ALIGN_CHECK=1 -> DONE with misalign flag set; else -> REQ.
  - Misaligned means addr[0]!=0 for half, addr[1:0]!=0 for word, addr[2:0]!=0 for double.
  - Illegal size (4-7) is treated as misaligned.
- REQ: dreq_valid=1; dreq_* driven from the latched registers only.
  - addr_ok=1 and data_ok=1 in the same cycle -> DONE, capture dresp_data.
  - addr_ok=1 only -> WAIT.
  - Otherwise stay; dreq_* held stable.
- WAIT: dreq_valid=0. data_ok=1 -> DONE, capture dresp_data; otherwise stay.
- DONE: done=1 for exactly this cycle, stall=0; -> IDLE unconditionally. req_valid is ignored in DONE, since it still shows the completing instruction.
- stall = req_valid & (state != DONE). In IDLE with req_valid, stall=1 combinationally.
- Minimum latency: req_valid seen in IDLE at cycle 0 -> done at cycle 2 (addr_ok & data_ok both in cycle 1).
- Misaligned path: done at cycle 1 with misalign=1, no dreq_valid ever asserted, mem_rdata=0.
- Store lanes, with sh = addr[2:0]*8:
  - dreq_data = req_wdata << sh.
  - dreq_strobe = (size mask 0x01/0x03/0x0F/0xFF) << addr[2:0], truncated to 8 bits.
- Load data:
  - raw = dresp_data >> sh.
  - Take low 8/16/32/64 bits; sign-extend from the top bit unless req_unsigned.
  - Double ignores req_unsigned.
- mem_rdata is registered at capture and held until the next capture. It is 0 for stores and misaligned accesses.
- Request inputs must stay stable while stall=1; the block samples them only in IDLE.
- data_ok while in IDLE/REQ-without-addr_ok is a bus protocol error: ignore it, no state change.
- Reset mid-access drops dreq_valid immediately. Any in-flight bus response arriving after reset is ignored (state IDLE).

Test Plan:
- Load double, addr 0x80000008, bus gives addr_ok+data_ok in same cycle with data 0x1122334455667788 -> done at cycle 2, mem_rdata=0x1122334455667788, stall high cycles 0-1.
- Signed byte load, addr 0x80000003, dresp_data 0x00000000_80000000, addr_ok cycle 1, data_ok cycle 4 -> done cycle 5, mem_rdata=0xFFFFFFFFFFFFFF80; unsigned repeat -> 0x80.
- Store word 0xDEADBEEF at addr 0x80000004 -> dreq_strobe=0xF0, dreq_data=0xDEADBEEF_00000000, dreq_valid held 3 cycles until addr_ok, done 2 cycles after addr_ok when data_ok follows next cycle.
- Half load at addr 0x80000001, ALIGN_CHECK=1 -> done at cycle 1 with misalign=1, dreq_valid never high; ALIGN_CHECK=0 -> bus request issued.
- Back-to-back loads: second req_valid present in DONE cycle is not reissued twice; exactly two dreq_valid handshakes observed.
- Assert reset while in WAIT, then data_ok arrives -> state IDLE, done stays 0, mem_rdata=0, stall follows req_valid.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer for the single data-bus port: runs one dbus
// request/response per load/store, stalls the pipeline and returns extended load data.
module mem_access_ctrl #(
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [63:0] mem_rdata,
  output logic        misalign,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  size_q;
  logic        unsigned_q, store_q, misalign_q;
  logic        req_misaligned, reject, capture;
  logic [5:0]  shift;
  logic [63:0] raw, load_ext;
  logic [7:0]  size_mask;

  // Illegal sizes are lumped in with misaligned accesses.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      3'd0:    req_misaligned = 1'b0;
      3'd1:    req_misaligned = req_addr[0];
      3'd2:    req_misaligned = |req_addr[1:0];
      3'd3:    req_misaligned = |req_addr[2:0];
      default: req_misaligned = 1'b1;
    endcase
  end

  assign reject = (ALIGN_CHECK != 0) && req_misaligned;

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: if (req_valid) state_next = reject ? DONE : REQ;
      REQ: begin
        // A data_ok without addr_ok is a bus protocol error and is ignored.
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            state_next = DONE;
            capture    = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (dresp_data_ok) begin
          state_next = DONE;
          capture    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      rdata_q    <= 64'd0;
      size_q     <= 3'd0;
      unsigned_q <= 1'b0;
      store_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        store_q    <= req_is_store;
        misalign_q <= reject;
        if (reject) rdata_q <= 64'd0;
      end
      if (capture) rdata_q <= store_q ? 64'd0 : load_ext;
    end
  end

  assign shift = {addr_q[2:0], 3'b000};
  assign raw   = dresp_data >> shift;

  always_comb begin
    load_ext = raw;
    case (size_q)
      3'd0: load_ext = unsigned_q ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      3'd1: load_ext = unsigned_q ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      3'd2: load_ext = unsigned_q ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: load_ext = raw;
    endcase
  end

  always_comb begin
    size_mask = 8'hFF;
    case (size_q)
      3'd0:    size_mask = 8'h01;
      3'd1:    size_mask = 8'h03;
      3'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Stall releases in DONE even though the completing instruction still drives req_valid.
  assign stall       = req_valid & (state != DONE);
  assign done        = (state == DONE);
  assign misalign    = done & misalign_q;
  assign mem_rdata   = rdata_q;
  assign dreq_valid  = (state == REQ);
  assign dreq_addr   = addr_q;
  assign dreq_size   = size_q;
  assign dreq_strobe = store_q ? (size_mask << addr_q[2:0]) : 8'h00;
  assign dreq_data   = wdata_q << shift;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random accesses
// on one aligned-checking and one pass-through instance, against an arithmetic model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid[2], req_is_store[2], req_unsigned[2];
  logic [63:0] req_addr[2], req_wdata[2];
  logic [2:0]  req_size[2];
  logic        stall[2], done[2], misalign[2], dreq_valid[2];
  logic [63:0] mem_rdata[2], dreq_addr[2], dreq_data[2];
  logic [2:0]  dreq_size[2];
  logic [7:0]  dreq_strobe[2];
  logic        dresp_addr_ok[2], dresp_data_ok[2];
  logic [63:0] dresp_data[2];

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_rd[2];
  int          hs_cnt[2];
  int          exp_hs[2];

  always #5 clk = ~clk;

  mem_access_ctrl #(.ALIGN_CHECK(1)) dut_chk (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_is_store(req_is_store[0]), .req_addr(req_addr[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]),
    .stall(stall[0]), .done(done[0]), .mem_rdata(mem_rdata[0]), .misalign(misalign[0]),
    .dreq_valid(dreq_valid[0]), .dreq_addr(dreq_addr[0]), .dreq_size(dreq_size[0]),
    .dreq_strobe(dreq_strobe[0]), .dreq_data(dreq_data[0]),
    .dresp_addr_ok(dresp_addr_ok[0]), .dresp_data_ok(dresp_data_ok[0]),
    .dresp_data(dresp_data[0])
  );

  mem_access_ctrl #(.ALIGN_CHECK(0)) dut_raw (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_is_store(req_is_store[1]), .req_addr(req_addr[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]),
    .stall(stall[1]), .done(done[1]), .mem_rdata(mem_rdata[1]), .misalign(misalign[1]),
    .dreq_valid(dreq_valid[1]), .dreq_addr(dreq_addr[1]), .dreq_size(dreq_size[1]),
    .dreq_strobe(dreq_strobe[1]), .dreq_data(dreq_data[1]),
    .dresp_addr_ok(dresp_addr_ok[1]), .dresp_data_ok(dresp_data_ok[1]),
    .dresp_data(dresp_data[1])
  );

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic model_mis(input logic [63:0] a, input logic [2:0] s);
    int m;
    if (s > 3'd3) return 1'b1;
    m = (1 << s) - 1;
    return (int'(a[2:0]) & m) != 0;
  endfunction

  function automatic logic [7:0] model_strobe(input logic st, input logic [63:0] a,
                                              input logic [2:0] s);
    int m;
    if (!st) return 8'h00;
    m = ((1 << (1 << s)) - 1) << int'(a[2:0]);
    return m[7:0];
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rsp, input logic [63:0] a,
                                             input logic [2:0] s, input logic uns);
    logic [63:0] r, mask, v;
    int bits;
    r = rsp >> (8 * int'(a[2:0]));
    bits = 8 * (1 << s);
    if (bits >= 64) return r;
    mask = (64'd1 << bits) - 64'd1;
    v = r & mask;
    if (!uns && r[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One complete access on instance u; aok = extra REQ cycles before addr_ok,
  // dok = cycles from addr_ok to data_ok (0 = same cycle).
  task automatic applyStimulus(input int u, input logic st, input logic [63:0] addr,
                               input logic [2:0] size, input logic uns, input logic [63:0] wdata,
                               input logic [63:0] rsp, input int aok, input int dok);
    logic        mis;
    int          done_cyc;
    logic [63:0] new_rd, old_rd;
    mis      = (u == 0) && model_mis(addr, size);
    done_cyc = mis ? 1 : 2 + aok + dok;
    new_rd   = (st || mis) ? 64'd0 : model_load(rsp, addr, size, uns);
    old_rd   = exp_rd[u];
    if (!mis) exp_hs[u]++;
    @(negedge clk);
    req_valid[u] = 1'b1; req_is_store[u] = st; req_addr[u] = addr;
    req_size[u] = size; req_unsigned[u] = uns; req_wdata[u] = wdata;
    dresp_addr_ok[u] = 1'b0; dresp_data_ok[u] = 1'b0;
    #1 checkOutput("stall_c0", 64'(stall[u]), 64'd1);
    for (int c = 1; c <= done_cyc; c++) begin
      @(negedge clk);
      checkOutput("stall", 64'(stall[u]), 64'(c != done_cyc));
      checkOutput("done", 64'(done[u]), 64'(c == done_cyc));
      checkOutput("misalign", 64'(misalign[u]), 64'((c == done_cyc) && mis));
      checkOutput("dreq_valid", 64'(dreq_valid[u]), 64'(!mis && c <= 1 + aok));
      checkOutput("mem_rdata", mem_rdata[u], (c == done_cyc) ? new_rd : old_rd);
      if (!mis && c <= 1 + aok) begin
        checkOutput("dreq_addr", dreq_addr[u], addr);
        checkOutput("dreq_size", 64'(dreq_size[u]), 64'(size));
        checkOutput("dreq_strobe", 64'(dreq_strobe[u]), 64'(model_strobe(st, addr, size)));
        checkOutput("dreq_data", dreq_data[u], wdata << (8 * int'(addr[2:0])));
      end
      dresp_addr_ok[u] = !mis && (c == 1 + aok);
      dresp_data_ok[u] = !mis && ((c == 1 + aok + dok) ||
                                  (c < 1 + aok && $urandom_range(1) == 1));
      dresp_data[u] = (c == 1 + aok + dok) ? rsp : rand64();
      if (dreq_valid[u] && dresp_addr_ok[u]) hs_cnt[u]++;
    end
    exp_rd[u] = new_rd;
  endtask

  task automatic idleCycles(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid[u] = 1'b0;
      #1;
      checkOutput("idle_stall", 64'(stall[u]), 64'd0);
      checkOutput("idle_done", 64'(done[u]), 64'd0);
      checkOutput("idle_dreq", 64'(dreq_valid[u]), 64'd0);
      checkOutput("idle_rdata", mem_rdata[u], exp_rd[u]);
    end
  endtask

  initial begin
    int hs_before;
    logic st, uns;
    logic [2:0] size;
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_is_store[u] = 1'b0; req_addr[u] = 64'd0;
      req_size[u] = 3'd0; req_unsigned[u] = 1'b0; req_wdata[u] = 64'd0;
      dresp_addr_ok[u] = 1'b0; dresp_data_ok[u] = 1'b0; dresp_data[u] = 64'd0;
      exp_rd[u] = 64'd0; hs_cnt[u] = 0; exp_hs[u] = 0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checkOutput("rst_stall", 64'(stall[u]), 64'd0);
      checkOutput("rst_done", 64'(done[u]), 64'd0);
      checkOutput("rst_misalign", 64'(misalign[u]), 64'd0);
      checkOutput("rst_rdata", mem_rdata[u], 64'd0);
      checkOutput("rst_dreq_valid", 64'(dreq_valid[u]), 64'd0);
      checkOutput("rst_dreq_addr", dreq_addr[u], 64'd0);
      checkOutput("rst_strobe", 64'(dreq_strobe[u]), 64'd0);
      checkOutput("rst_dreq_data", dreq_data[u], 64'd0);
    end
    reset = 1'b0;
    $display("[TB] directed accesses");

    applyStimulus(0, 1'b0, 64'h8000_0008, 3'd3, 1'b0, 64'd0, 64'h1122_3344_5566_7788, 0, 0);
    checkOutput("ld_double", mem_rdata[0], 64'h1122_3344_5566_7788);
    idleCycles(0, 1);
    applyStimulus(0, 1'b0, 64'h8000_0003, 3'd0, 1'b0, 64'd0, 64'h0000_0000_8000_0000, 0, 3);
    checkOutput("ld_byte_s", mem_rdata[0], 64'hFFFF_FFFF_FFFF_FF80);
    idleCycles(0, 1);
    applyStimulus(0, 1'b0, 64'h8000_0003, 3'd0, 1'b1, 64'd0, 64'h0000_0000_8000_0000, 0, 3);
    checkOutput("ld_byte_u", mem_rdata[0], 64'h80);
    idleCycles(0, 1);

    $display("[TB] reset during REQ and WAIT");
    @(negedge clk);
    req_valid[0] = 1'b1; req_is_store[0] = 1'b0; req_addr[0] = 64'h8000_0010;
    req_size[0] = 3'd3; req_unsigned[0] = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_req", 64'(dreq_valid[0]), 64'd1);
    reset = 1'b1;
    #1 checkOutput("rst_drop_req", 64'(dreq_valid[0]), 64'd0);
    checkOutput("rst_rdata_clr", mem_rdata[0], 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dresp_addr_ok[0] = 1'b1;
    @(negedge clk);
    dresp_addr_ok[0] = 1'b0;
    checkOutput("wait_no_req", 64'(dreq_valid[0]), 64'd0);
    checkOutput("wait_stall", 64'(stall[0]), 64'd1);
    #2 reset = 1'b1;
    #1 checkOutput("rst_wait_done", 64'(done[0]), 64'd0);
    checkOutput("rst_wait_stall", 64'(stall[0]), 64'(req_valid[0]));
    @(negedge clk);
    reset = 1'b0; req_valid[0] = 1'b0;
    dresp_data_ok[0] = 1'b1; dresp_data[0] = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    dresp_data_ok[0] = 1'b0;
    exp_rd[0] = 64'd0; exp_rd[1] = 64'd0;
    checkOutput("late_resp_done", 64'(done[0]), 64'd0);
    checkOutput("late_resp_rdata", mem_rdata[0], 64'd0);
    checkOutput("late_resp_stall", 64'(stall[0]), 64'd0);
    idleCycles(0, 2);

    $display("[TB] store, misaligned and back-to-back");
    applyStimulus(0, 1'b1, 64'h8000_0004, 3'd2, 1'b0, 64'hDEAD_BEEF, 64'd0, 2, 1);
    idleCycles(0, 1);
    applyStimulus(0, 1'b0, 64'h8000_0001, 3'd1, 1'b0, 64'd0, 64'h0000_0000_00AB_CD00, 0, 0);
    idleCycles(0, 1);
    applyStimulus(0, 1'b0, 64'h8000_0000, 3'd5, 1'b0, 64'd0, 64'h1, 0, 0);
    idleCycles(0, 1);
    applyStimulus(1, 1'b0, 64'h8000_0001, 3'd1, 1'b0, 64'd0, 64'h0000_0000_00AB_CD00, 0, 0);
    checkOutput("raw_misaligned_ld", mem_rdata[1], 64'hFFFF_FFFF_FFFF_ABCD);
    idleCycles(1, 1);
    hs_before = hs_cnt[0];
    applyStimulus(0, 1'b0, 64'h8000_0020, 3'd2, 1'b1, 64'd0, 64'h0000_0000_8765_4321, 0, 0);
    applyStimulus(0, 1'b0, 64'h8000_0026, 3'd1, 1'b0, 64'd0, 64'h7FFF_0000_0000_0000, 1, 0);
    idleCycles(0, 2);
    checkOutput("b2b_handshakes", 64'(hs_cnt[0] - hs_before), 64'd2);

    $display("[TB] random accesses");
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 30; i++) begin
        st   = 1'($urandom_range(1));
        uns  = 1'($urandom_range(1));
        size = 3'($urandom_range(3));
        if (u == 0 && $urandom_range(7) == 0) size = 3'(4 + $urandom_range(3));
        applyStimulus(u, st, rand64(), size, uns, rand64(), rand64(),
                      int'($urandom_range(3)), int'($urandom_range(3)));
        idleCycles(u, int'($urandom_range(2)));
      end
      idleCycles(u, 1);
      checkOutput("handshakes", 64'(hs_cnt[u]), 64'(exp_hs[u]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
